rca_nibble_sequencer: RTL and testbench

//  Multi-cycle WIDTH-bit adder that time-shares one 4-bit ripple-carry slice.

---
 rtl/rca_pkg.sv | 24 ++
 rtl/nibble_rca.sv | 31 +++
 rtl/rca_nibble_sequencer.sv | 149 ++++++++++++++
 tb/tb_rca_nibble_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// ============================================================================
// Module   : rca_pkg
// Brief    : Shared slice width, sequencer state encoding and slice-count helper
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rca_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic int nslices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_rca.sv
// ============================================================================
// Module   : nibble_rca
// Brief    : Purely combinational SLICE_W-bit ripple-carry adder slice
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_rca
    import rca_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign co = w_c[SLICE_W];

endmodule

`default_nettype wire

// File: rtl/rca_nibble_sequencer.sv
// ============================================================================
// Module   : rca_nibble_sequencer
// Brief    : WIDTH-bit adder time-sharing one nibble ripple-carry slice, LSB
//            first, with valid/ready handshakes on operands and result.
//            Optional macro OVERFLOW_FLAG_EN adds the signed-overflow output ovf.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rca_nibble_sequencer
    import rca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef OVERFLOW_FLAG_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int C_NSLICES = nslices(WIDTH);
    localparam int C_IDX_W   = (C_NSLICES > 1) ? $clog2(C_NSLICES) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST = C_IDX_W'(C_NSLICES - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
        $error("rca_nibble_sequencer: WIDTH must be a positive multiple of %0d", SLICE_W);
    end

    seq_state_t           r_state;
    seq_state_t           w_state_next;
    logic [C_IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_carry;
    logic [SLICE_W-1:0]   r_sum_nib [C_NSLICES];
    logic                 r_cout;

    logic [SLICE_W-1:0]   w_a_nib [C_NSLICES];
    logic [SLICE_W-1:0]   w_b_nib [C_NSLICES];
    logic [SLICE_W-1:0]   w_x;
    logic [SLICE_W-1:0]   w_y;
    logic [SLICE_W-1:0]   w_s;
    logic                 w_co;
    logic                 w_accept;
    logic                 w_step;
    logic                 w_last;

    // Nibble views of the latched operands and the result register
    for (genvar i = 0; i < C_NSLICES; i++) begin : g_nib
        assign w_a_nib[i]                   = r_a[i*SLICE_W +: SLICE_W];
        assign w_b_nib[i]                   = r_b[i*SLICE_W +: SLICE_W];
        assign sum[i*SLICE_W +: SLICE_W]    = r_sum_nib[i];
    end

    assign w_x = w_a_nib[r_idx];
    assign w_y = w_b_nib[r_idx];

    nibble_rca u_slice (
        .x  (w_x),
        .y  (w_y),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_step   = (r_state == RUN);
    assign w_last   = w_step && (r_idx == C_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            for (int i = 0; i < C_NSLICES; i++) begin
                r_sum_nib[i] <= '0;
            end
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
        end else if (w_step) begin
            r_sum_nib[r_idx] <= w_s;
            r_carry          <= w_co;
            r_idx            <= w_last ? '0 : r_idx + C_IDX_W'(1);
            if (w_last) begin
                r_cout <= w_co;
            end
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic r_ovf;
    logic w_msb_cin;

    // Carry into the MSB recovered from the slice's top sum bit
    assign w_msb_cin = w_x[SLICE_W-1] ^ w_y[SLICE_W-1] ^ w_s[SLICE_W-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= w_msb_cin ^ w_co;
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == RUN) || (r_state == DONE);
    assign cout      = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_rca_nibble_sequencer.sv
// ============================================================================
// Module   : tb_rca_nibble_sequencer
// Brief    : Self-checking bench: directed cases plus randomized operations
//            compared against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rca_nibble_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } op_t;

    op_t sb_q[$];

    always #5 clk = ~clk;

    rca_nibble_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef OVERFLOW_FLAG_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint r;
        r = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        return (r > 32767) || (r < -32768);
    endfunction

    // One full transaction: offer operands, follow RUN, hold in DONE, release.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input int hold, input bit noise);
        int       guard;
        int       lat;
        op_t      o;
        op_t      e;
        logic [W:0] exp;
        a        = ta;
        b        = tb;
        cin      = tc;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        tick();
        o.a = ta; o.b = tb; o.cin = tc;
        sb_q.push_back(o);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            check("in_ready_low_busy", {30'd0, in_ready, busy}, 32'd1);
            if (noise) begin
                in_valid  = 1'($urandom % 2);
                a         = W'($urandom);
                b         = W'($urandom);
                cin       = 1'($urandom % 2);
                out_ready = 1'($urandom % 2);
            end
            tick();
            lat++;
        end
        check("latency", lat, 32'd4);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e   = sb_q.pop_front();
        exp = ref_add(e.a, e.b, e.cin);
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            if (noise) begin
                in_valid = 1'($urandom % 2);
                a        = W'($urandom);
            end
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_sum", {15'd0, cout, sum}, {15'd0, exp});
        end
        check("sum", {16'd0, sum}, {16'd0, exp[W-1:0]});
        check("cout", {31'd0, cout}, {31'd0, exp[W]});
`ifdef OVERFLOW_FLAG_EN
        check("ovf", {31'd0, ovf}, {31'd0, ref_ovf(e.a, e.b, e.cin)});
`endif
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        check("release_state", {29'd0, out_valid, in_ready, busy}, 32'b010);
        check("idle_sum_held", {15'd0, cout, sum}, {15'd0, exp});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        tick();
        check("reset_ctrl", {29'd0, out_valid, in_ready, busy}, 32'b010);
        check("reset_sum", {15'd0, cout, sum}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b1, 1, 1'b0);
        run_op(16'h000E, 16'h0009, 1'b1, 5, 1'b1);

        // Abort an operation mid-run with a one-cycle reset
        a = 16'h5A5A; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_run_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_ctrl", {29'd0, out_valid, in_ready, busy}, 32'b010);
        check("abort_sum", {15'd0, cout, sum}, 32'd0);
        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            int           gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                in_valid  = 1'b0;
                out_ready = 1'($urandom % 2);
                tick();
                check("gap_idle", {29'd0, out_valid, in_ready, busy}, 32'b010);
            end
            case ($urandom % 4)
                0:       begin ra = 16'hFFFF; rb = W'($urandom); end
                1:       begin ra = W'($urandom % 16); rb = 16'hFFFF - ra; end
                default: begin ra = W'($urandom); rb = W'($urandom); end
            endcase
            run_op(ra, rb, 1'($urandom % 2), $urandom_range(0, 3), 1'b1);
        end
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
